div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Next-generation iterative integer divider for the ALU extension set.
- Width is parametrised. Supports unsigned and signed (truncating) division.
- Uses a valid/ready handshake on both input and output, with a latched result.
- Sits beside mult/shifter and serves the Forth /, MOD, /MOD, U/MOD opcodes. One request is in flight at a time; one quotient bit is produced per cycle.

Parameters:
- DSZ, 32, operand/result width in bits (>= 4).
- CSZ, $clog2(DSZ)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  divider idle and able to accept a request.
- sgn  in  1  1 = signed operands, 0 = unsigned; sampled with the request.
- x  in  DSZ  dividend.
- y  in  DSZ  divisor.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- q  out  DSZ  quotient.
- r  out  DSZ  remainder.
- dbz  out  1  divide-by-zero flag for this result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; q, r, remainder accumulator, counter all 0; out_valid=0, dbz=0, busy=0; in_ready=1 after rst_n deasserts.
- Reset mid-operation aborts the request; the result is discarded and no out_valid is produced.
- States and transitions:
  - IDLE → CALC on in_valid&&in_ready, when y!=0.
  - IDLE → DONE when y==0.
  - CALC → FIX after DSZ iterations.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE). Outputs change only in DONE.
- Accept: latch |x|, |y| (magnitudes when sgn=1, raw otherwise), the quotient sign (x[MSB]^y[MSB])&sgn, and the remainder sign x[MSB]&sgn.
- CALC: restoring step on a DSZ+1-bit accumulator.
  - Shift {acc, dividend} left by 1.
  - If acc >= {1'b0, |y|}: acc -= |y| and the quotient bit = 1; otherwise the bit = 0.
  - Counter runs 0..DSZ-1.
- FIX: negate the quotient if its sign is set; negate the remainder if its sign is set. Truncation toward zero; the remainder takes the dividend's sign.
- Latency: request accepted at edge k → out_valid high from edge k+DSZ+2. Divide-by-zero → out_valid at edge k+1.
- Divide-by-zero result: q = all ones, r = x (raw), dbz=1.
- Signed overflow (x = most-negative, y = -1, sgn=1): q = most-negative, r = 0, dbz=0. This falls out naturally from the magnitude path; no special case is needed.
- DONE holds q/r/dbz/out_valid stable until out_ready. On the out_ready cycle out_valid drops next edge and in_ready rises.
- No new request is accepted in the same cycle as result handoff (no back-to-back overlap).
- out_ready asserted while out_valid=0 is ignored. in_valid while busy is ignored (not queued).
- y changing after acceptance has no effect: operands are latched.

Optional Feature:
- DIV_SIGNED_EN.
- Defined: sgn port honoured as above, and FIX performs the sign correction.
- Undefined: sgn is ignored (treated as 0), FIX is a single pass-through cycle, the sign/negate logic is removed, and latency is unchanged.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_st_t {IDLE, CALC, FIX, DONE}.
  - localparam DIV_ALL1 for the dbz quotient.
  - function abs_val (parametrised via DSZ-width typedef) and function neg.
- One sub-module div_step (combinational): inputs acc, dividend MSB, divisor; outputs next acc and quotient bit. It is instantiated once in div_seq, and later replicated for a radix-4 variant.

Test Plan:
- Unsigned: x=100, y=7, sgn=0 → q=14, r=2, dbz=0, out_valid exactly DSZ+2 cycles after accept (34 for DSZ=32).
- Signed: x=-100, y=7, sgn=1 → q=-14 (0xFFFFFFF2), r=-2 (0xFFFFFFFE). Also x=100, y=-7 → q=-14, r=2.
- Divide-by-zero: x=0x12345678, y=0 → out_valid next cycle, q=0xFFFFFFFF, r=0x12345678, dbz=1. The following request x=9, y=3 clears dbz and gives q=3, r=0.
- Overflow/edge: x=0x80000000, y=-1, sgn=1 → q=0x80000000, r=0. Also unsigned x=0xFFFFFFFF, y=1 → q=0xFFFFFFFF, r=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → q/r stable, in_ready=0, in_valid pulses ignored. Release → in_ready=1 the next cycle.
- Async reset: assert rst_n=0 at iteration 15 → busy/out_valid drop immediately with no clock. After release, a fresh request 50/5 → q=10, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM state encoding,
// the divide-by-zero quotient pattern and two's-complement magnitude helpers.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_st_t;

  // Helpers work on a 64-bit word; callers sign-extend in and truncate out,
  // so any operand width up to 64 bits is covered.
  localparam int DIV_WMAX = 64;
  typedef logic [DIV_WMAX-1:0] div_word_t;

  localparam div_word_t DIV_ALL1 = '1;

  function automatic div_word_t neg(input div_word_t v);
    return ~v + div_word_t'(1);
  endfunction

  function automatic div_word_t abs_val(input div_word_t v);
    return v[DIV_WMAX-1] ? neg(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// accumulator and subtract the divisor when it fits.
module div_step #(
  parameter int DSZ = 32
) (
  input  logic [DSZ:0]   acc,
  input  logic           dmsb,
  input  logic [DSZ-1:0] dvs,
  output logic [DSZ:0]   acc_nxt,
  output logic           qbit
);

  logic [DSZ+1:0] sh;
  logic [DSZ:0]   diff;

  always_comb begin
    sh   = {acc, dmsb};
    qbit = (sh >= {2'b00, dvs});
    // When the subtraction is taken the result is below 2^DSZ, so the
    // truncated difference is exact.
    diff    = sh[DSZ:0] - {1'b0, dvs};
    acc_nxt = qbit ? diff : sh[DSZ:0];
  end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, valid/ready
// on both sides. Define DIV_SIGNED_EN to honour sgn (truncating signed divide).
module div_seq
  import div_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int CSZ = $clog2(DSZ) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sgn,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r,
  output logic           dbz,
  output logic           busy
);

  div_st_t        st_q, st_d;
  logic [DSZ:0]   acc_q, acc_d;
  logic [DSZ-1:0] dvd_q, dvd_d;
  logic [DSZ-1:0] dvs_q, dvs_d;
  logic [CSZ-1:0] cnt_q, cnt_d;
  logic [DSZ-1:0] q_q, q_d;
  logic [DSZ-1:0] r_q, r_d;
  logic           dbzp_q, dbzp_d;
  logic           dbz_q, dbz_d;
  logic           ov_q, ov_d;

  logic [DSZ-1:0] x_mag, y_mag;
  logic [DSZ:0]   step_acc;
  logic           step_qbit;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  always_comb begin
    x_mag = sgn ? DSZ'(abs_val(div_word_t'($signed(x)))) : x;
    y_mag = sgn ? DSZ'(abs_val(div_word_t'($signed(y)))) : y;
  end
`else
  logic sgn_unused;
  assign sgn_unused = sgn;

  always_comb begin
    x_mag = x;
    y_mag = y;
  end
`endif

  // The dividend register doubles as the quotient: its MSB is shifted into
  // the accumulator while the new quotient bit enters at the LSB.
  div_step #(.DSZ(DSZ)) u_step (
    .acc     (acc_q),
    .dmsb    (dvd_q[DSZ-1]),
    .dvs     (dvs_q),
    .acc_nxt (step_acc),
    .qbit    (step_qbit)
  );

  always_comb begin
    st_d   = st_q;
    acc_d  = acc_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    dbzp_d = dbzp_q;
    dbz_d  = dbz_q;
    ov_d   = ov_q;
`ifdef DIV_SIGNED_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    case (st_q)
      IDLE: begin
        if (in_valid) begin
          if (y == '0) begin
            st_d   = DONE;
            dvd_d  = DSZ'(DIV_ALL1);
            acc_d  = {1'b0, x};
            dbzp_d = 1'b1;
          end else begin
            st_d   = CALC;
            acc_d  = '0;
            dvd_d  = x_mag;
            dvs_d  = y_mag;
            cnt_d  = '0;
            dbzp_d = 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_d = (x[DSZ-1] ^ y[DSZ-1]) & sgn;
            rneg_d = x[DSZ-1] & sgn;
`endif
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        dvd_d = {dvd_q[DSZ-2:0], step_qbit};
        cnt_d = cnt_q + CSZ'(1);
        if (cnt_q == CSZ'(DSZ - 1)) begin
          st_d = FIX;
        end
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        if (qneg_q) begin
          dvd_d = DSZ'(neg(div_word_t'(dvd_q)));
        end
        if (rneg_q) begin
          acc_d = {1'b0, DSZ'(neg(div_word_t'(acc_q[DSZ-1:0])))};
        end
`endif
        st_d = DONE;
      end
      DONE: begin
        // First DONE cycle loads the result; out_ready only counts once
        // out_valid is already high.
        if (!ov_q) begin
          q_d   = dvd_q;
          r_d   = acc_q[DSZ-1:0];
          dbz_d = dbzp_q;
          ov_d  = 1'b1;
        end else if (out_ready) begin
          ov_d = 1'b0;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      acc_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      dbzp_q <= 1'b0;
      dbz_q  <= 1'b0;
      ov_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      acc_q  <= acc_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dbzp_q <= dbzp_d;
      dbz_q  <= dbz_d;
      ov_q   <= ov_d;
`ifdef DIV_SIGNED_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign out_valid = ov_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases, backpressure, async reset
// and randomized division checked against an arithmetic reference model.
module tb_div_seq;

  localparam int DSZ = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           sgn = 1'b0;
  logic [DSZ-1:0] x = '0;
  logic [DSZ-1:0] y = '0;
  logic           out_ready = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [DSZ-1:0] q;
  logic [DSZ-1:0] r;
  logic           dbz;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int txn   = 0;

  div_seq #(.DSZ(DSZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sgn       (sgn),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; signed uses 64-bit truncating math.
  function automatic void model(input logic [31:0] xi, input logic [31:0] yi, input logic si,
                                output logic [31:0] eq, output logic [31:0] er, output logic ed);
    logic   s_eff;
    longint sx, sy;
`ifdef DIV_SIGNED_EN
    s_eff = si;
`else
    s_eff = 1'b0 & si;
`endif
    if (yi == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = xi;
      ed = 1'b1;
    end else if (s_eff) begin
      sx = longint'($signed(xi));
      sy = longint'($signed(yi));
      eq = 32'(sx / sy);
      er = 32'(sx % sy);
      ed = 1'b0;
    end else begin
      eq = xi / yi;
      er = xi % yi;
      ed = 1'b0;
    end
  endfunction

  // Issue one request, wait for the result, optionally stall, then hand off.
  task automatic run_div(input logic [31:0] xi, input logic [31:0] yi, input logic si,
                         input int hold, input logic early_ready);
    logic [31:0] eq, er;
    logic        ed;
    int          lat;
    int          exp_lat;
    model(xi, yi, si, eq, er, ed);
    exp_lat = (yi == 32'd0) ? 1 : DSZ + 2;
    chk("in_ready_before_req", 64'(in_ready), 64'd1);
    x = xi;
    y = yi;
    sgn = si;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = $urandom;
    y = $urandom;
    sgn = 1'($urandom_range(0, 1));
    out_ready = early_ready;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("q", 64'(q), 64'(eq));
    chk("r", 64'(r), 64'(er));
    chk("dbz", 64'(dbz), 64'(ed));
    $display("txn %0d: x=%h y=%h sgn=%0d -> q=%h r=%h dbz=%0d lat=%0d (exp q=%h r=%h)",
             txn, xi, yi, si, q, r, dbz, lat, eq, er);
    txn++;
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      x = $urandom;
      y = $urandom;
      @(posedge clk);
      #1;
      chk("hold_q", 64'(q), 64'(eq));
      chk("hold_r", 64'(r), 64'(er));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", 64'(out_valid), 64'd0);
    chk("handoff_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic        rs;
    int          pick;

    #12;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_div(-32'sd100, 32'd7, 1'b1, 0, 1'b0);
    run_div(32'd100, -32'sd7, 1'b1, 0, 1'b0);
    run_div(32'h1234_5678, 32'd0, 1'b0, 0, 1'b0);
    run_div(32'd9, 32'd3, 1'b0, 0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0);
    run_div(32'd1000, 32'd33, 1'b0, 10, 1'b0);

    // Abort an in-flight request with reset between clock edges.
    x = 32'd1000;
    y = 32'd3;
    sgn = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_q", 64'(q), 64'd0);
    chk("arst_r", 64'(r), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    run_div(32'd50, 32'd5, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rx = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
      pick = $urandom_range(0, 9);
      case (pick)
        0:       ry = 32'd0;
        1:       ry = 32'd1;
        2:       ry = 32'hFFFF_FFFF;
        3:       ry = 32'($urandom_range(1, 15));
        4:       ry = -32'($urandom_range(1, 15));
        default: ry = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_div(rx, ry, rs, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
